tcp_tx_session_sequencer: RTL and testbench

Sequences the TCP TX path for result packets. It pops one session ID from the metadata queue and issues a tx-metadata request with the payload length. It then waits for the stack's tx-status reply and, based on that status, either forwards, drops or retries the matching data packet from the result FIFO. It sits between the result/metadata FIFOs and the stack's m_axis_tx_metadata / m_axis_tx_data / s_axis_tx_status interfaces, and replaces ad-hoc token handshake logic.

---
 rtl/tcp_tx_session_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tcp_tx_session_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_session_sequencer.sv
// TCP TX sequencer: pops a session, requests tx-metadata, then forwards/drops/retries the result packet
// according to the stack's tx-status reply. Define TX_STATS_EN to build the sent/dropped/retried counters.
module tcp_tx_session_sequencer #(
    parameter int PKT_LEN        = 64,
    parameter int BACKOFF_CYCLES = 256,
    parameter int STS_TIMEOUT    = 4096,
    parameter int MAX_RETRY      = 8
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         s_meta_valid,
    output logic         s_meta_ready,
    input  logic [15:0]  s_meta_data,
    input  logic         s_data_valid,
    output logic         s_data_ready,
    input  logic [511:0] s_data_data,
    input  logic         s_data_last,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST,
    output logic         busy,
    output logic [31:0]  stat_sent,
    output logic [31:0]  stat_dropped,
    output logic [31:0]  stat_retried
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DROP, BACKOFF} state_t;

    localparam int TO_W = $clog2(STS_TIMEOUT) + 1;
    localparam int BO_W = $clog2(BACKOFF_CYCLES) + 1;
    localparam int RT_W = $clog2(MAX_RETRY) + 1;
    localparam logic [15:0] LEN16 = 16'(PKT_LEN);

    state_t          state_reg, state_next;
    logic [15:0]     session_reg, session_next;
    logic [RT_W-1:0] retry_reg, retry_next;
    logic [TO_W-1:0] timeout_reg, timeout_next;
    logic [BO_W-1:0] backoff_reg, backoff_next;
    logic [1:0]      sts_code;
    logic            unused_sts;

    assign sts_code   = s_axis_tx_status_TDATA[63:62];
    assign unused_sts = ^s_axis_tx_status_TDATA[61:0];
    assign m_axis_tx_data_TKEEP = '1;
    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            session_reg <= '0;
            retry_reg   <= '0;
            timeout_reg <= '0;
            backoff_reg <= '0;
        end else begin
            state_reg   <= state_next;
            session_reg <= session_next;
            retry_reg   <= retry_next;
            timeout_reg <= timeout_next;
            backoff_reg <= backoff_next;
        end
    end

    always_comb begin
        state_next                = state_reg;
        session_next              = session_reg;
        retry_next                = retry_reg;
        timeout_next              = timeout_reg;
        backoff_next              = backoff_reg;
        s_meta_ready              = 1'b0;
        s_data_ready              = 1'b0;
        m_axis_tx_metadata_TVALID = 1'b0;
        m_axis_tx_metadata_TDATA  = '0;
        s_axis_tx_status_TREADY   = 1'b0;
        m_axis_tx_data_TVALID     = 1'b0;
        m_axis_tx_data_TDATA      = '0;
        m_axis_tx_data_TLAST      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gate the pop with reset so a queued session is not lost while the FIFO is being cleared.
                if (s_meta_valid && aresetn) begin
                    s_meta_ready = 1'b1;
                    session_next = s_meta_data;
                    retry_next   = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                m_axis_tx_metadata_TVALID = 1'b1;
                m_axis_tx_metadata_TDATA  = {LEN16, session_reg};
                if (m_axis_tx_metadata_TREADY) begin
                    timeout_next = '0;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                s_axis_tx_status_TREADY = 1'b1;
                timeout_next = timeout_reg + 1'b1;
                if (s_axis_tx_status_TVALID) begin
                    case (sts_code)
                        2'd0: state_next = SEND;
                        2'd2: begin
                            if (retry_reg < RT_W'(MAX_RETRY - 1)) begin
                                retry_next   = retry_reg + 1'b1;
                                backoff_next = '0;
                                state_next   = BACKOFF;
                            end else begin
                                state_next = DROP;
                            end
                        end
                        default: state_next = DROP;
                    endcase
                end else if (timeout_reg == TO_W'(STS_TIMEOUT - 1)) begin
                    state_next = DROP;
                end
            end
            SEND: begin
                m_axis_tx_data_TVALID = s_data_valid;
                m_axis_tx_data_TDATA  = s_data_data;
                m_axis_tx_data_TLAST  = s_data_last;
                s_data_ready          = m_axis_tx_data_TREADY;
                if (s_data_valid && m_axis_tx_data_TREADY && s_data_last)
                    state_next = IDLE;
            end
            DROP: begin
                s_data_ready = 1'b1;
                if (s_data_valid && s_data_last)
                    state_next = IDLE;
            end
            BACKOFF: begin
                backoff_next = backoff_reg + 1'b1;
                if (backoff_reg == BO_W'(BACKOFF_CYCLES - 1))
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TX_STATS_EN
    logic [2:0]       stat_evt;
    logic [2:0][31:0] stat_vec;

    assign stat_evt[0] = (state_reg == SEND) && s_data_valid && m_axis_tx_data_TREADY && s_data_last;
    assign stat_evt[1] = (state_reg == DROP) && s_data_valid && s_data_last;
    assign stat_evt[2] = (state_reg == BACKOFF) && (backoff_reg == BO_W'(BACKOFF_CYCLES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!aresetn)
                    cnt_reg <= '0;
                else if (stat_evt[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + 1'b1;
            end
            assign stat_vec[gi] = cnt_reg;
        end
    endgenerate

    assign stat_sent    = stat_vec[0];
    assign stat_dropped = stat_vec[1];
    assign stat_retried = stat_vec[2];
`else
    assign stat_sent    = '0;
    assign stat_dropped = '0;
    assign stat_retried = '0;
`endif

endmodule

// File: tb/tb_tcp_tx_session_sequencer.sv
// Directed bench for tcp_tx_session_sequencer: ok/drop/retry/timeout/backpressure/reset scenarios.
module tb_tcp_tx_session_sequencer;

    localparam int TB_BACKOFF = 16;
    localparam int TB_TIMEOUT = 40;
`ifdef TX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_meta_valid = 1'b0;
    logic         s_meta_ready;
    logic [15:0]  s_meta_data = '0;
    logic         s_data_valid = 1'b0;
    logic         s_data_ready;
    logic [511:0] s_data_data = '0;
    logic         s_data_last = 1'b0;
    logic         meta_tvalid;
    logic         meta_tready = 1'b0;
    logic [31:0]  meta_tdata;
    logic         sts_tvalid = 1'b0;
    logic         sts_tready;
    logic [63:0]  sts_tdata = '0;
    logic         tx_tvalid;
    logic         tx_tready = 1'b0;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tkeep;
    logic         tx_tlast;
    logic         busy;
    logic [31:0]  stat_sent, stat_dropped, stat_retried;

    int errors = 0;
    int checks = 0;
    int k;

    always #5 clk = ~clk;

    tcp_tx_session_sequencer #(
        .PKT_LEN(64), .BACKOFF_CYCLES(TB_BACKOFF), .STS_TIMEOUT(TB_TIMEOUT), .MAX_RETRY(8)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
        .s_data_last(s_data_last),
        .m_axis_tx_metadata_TVALID(meta_tvalid), .m_axis_tx_metadata_TREADY(meta_tready),
        .m_axis_tx_metadata_TDATA(meta_tdata),
        .s_axis_tx_status_TVALID(sts_tvalid), .s_axis_tx_status_TREADY(sts_tready),
        .s_axis_tx_status_TDATA(sts_tdata),
        .m_axis_tx_data_TVALID(tx_tvalid), .m_axis_tx_data_TREADY(tx_tready),
        .m_axis_tx_data_TDATA(tx_tdata), .m_axis_tx_data_TKEEP(tx_tkeep),
        .m_axis_tx_data_TLAST(tx_tlast),
        .busy(busy), .stat_sent(stat_sent), .stat_dropped(stat_dropped), .stat_retried(stat_retried)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input int sent, input int dropped, input int retried);
        chk("stat_sent", stat_sent, STATS_ON ? 32'(sent) : 32'd0);
        chk("stat_dropped", stat_dropped, STATS_ON ? 32'(dropped) : 32'd0);
        chk("stat_retried", stat_retried, STATS_ON ? 32'(retried) : 32'd0);
    endtask

    function automatic logic [511:0] beat_word(input int x);
        return {16{32'hC0DE0000 | 32'(x)}};
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge where REQ is presented.
    task automatic send_meta(input logic [15:0] sid);
        s_meta_valid = 1'b1;
        s_meta_data  = sid;
        #1;
        chk("meta_pop", s_meta_ready, 1'b1);
        @(negedge clk);
        s_meta_valid = 1'b0;
        #1;
        chk("meta_pop_pulse", s_meta_ready, 1'b0);
    endtask

    // Holds TREADY low for 'hold' cycles, then completes the metadata handshake; ends in WAIT.
    task automatic accept_req(input logic [15:0] sid, input int hold);
        chk("req_valid", meta_tvalid, 1'b1);
        chk("req_data", meta_tdata, {16'h0040, sid});
        for (int i = 0; i < hold; i++) begin
            meta_tready = 1'b0;
            @(negedge clk);
            chk("req_hold_valid", meta_tvalid, 1'b1);
            chk("req_hold_data", meta_tdata, {16'h0040, sid});
        end
        meta_tready = 1'b1;
        @(negedge clk);
        meta_tready = 1'b0;
        #1;
        chk("wait_sts_ready", sts_tready, 1'b1);
        chk("wait_req_valid", meta_tvalid, 1'b0);
    endtask

    task automatic give_status(input logic [1:0] code, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_sts_ready_hold", sts_tready, 1'b1);
        end
        sts_tvalid = 1'b1;
        sts_tdata  = {code, 62'h1234};
        #1;
        chk("sts_accept", sts_tready, 1'b1);
        @(negedge clk);
        sts_tvalid = 1'b0;
        sts_tdata  = '0;
    endtask

    // Offers n beats; fwd selects forward (SEND) or discard (DROP) expectations.
    task automatic stream(input int n, input int base, input logic fwd, input logic toggle);
        int b;
        int cyc;
        logic rdy;
        logic hs;
        b = 0;
        cyc = 0;
        while (b < n && cyc < 64) begin
            rdy = toggle ? cyc[0] : 1'b1;
            s_data_valid = 1'b1;
            s_data_data  = beat_word(base + b);
            s_data_last  = (b == n - 1);
            tx_tready    = rdy;
            #1;
            hs = fwd ? rdy : 1'b1;
            if (fwd) begin
                chk("tx_valid", tx_tvalid, 1'b1);
                chk("tx_data", tx_tdata, beat_word(base + b));
                chk("tx_last", tx_tlast, (b == n - 1));
                chk("tx_keep", tx_tkeep, {64{1'b1}});
            end else begin
                chk("drop_tx_valid", tx_tvalid, 1'b0);
            end
            chk("in_ready", s_data_ready, hs);
            if (hs) b++;
            @(negedge clk);
            cyc++;
        end
        chk("stream_beats", 32'(b), 32'(n));
        s_data_valid = 1'b0;
        s_data_last  = 1'b0;
        tx_tready    = 1'b0;
        #1;
        chk("back_to_idle", busy, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        s_meta_valid = 1'b1;
        #1;
        chk("rst_meta_ready", s_meta_ready, 1'b0);
        chk("rst_req_valid", meta_tvalid, 1'b0);
        chk("rst_req_data", meta_tdata, 32'h0);
        chk("rst_sts_ready", sts_tready, 1'b0);
        chk("rst_tx_valid", tx_tvalid, 1'b0);
        chk("rst_in_ready", s_data_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk_stats(0, 0, 0);
        s_meta_valid = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);

        // 1: OK status after 3 cycles, one beat forwarded
        send_meta(16'h0005);
        chk("t1_busy", busy, 1'b1);
        chk("t1_meta_tdata", meta_tdata, 32'h0040_0005);
        accept_req(16'h0005, 0);
        give_status(2'd0, 2);
        stream(1, 16'h10, 1'b1, 1'b0);
        chk_stats(1, 0, 0);

        // 2: no-connection status, two beats discarded, next session popped immediately
        send_meta(16'h0011);
        accept_req(16'h0011, 0);
        give_status(2'd1, 1);
        stream(2, 16'h20, 1'b0, 1'b0);
        chk_stats(1, 1, 0);

        // 3: no-space twice then OK
        send_meta(16'h0100);
        accept_req(16'h0100, 0);
        for (int r = 0; r < 2; r++) begin
            give_status(2'd2, 1);
            k = 0;
            while (!meta_tvalid && k < 100) begin
                if (k == 0) chk("backoff_sts_ready", sts_tready, 1'b0);
                if (k == 0) chk("backoff_in_ready", s_data_ready, 1'b0);
                @(negedge clk);
                k++;
            end
            chk("backoff_gap_min", (k >= TB_BACKOFF), 1'b1);
            chk("backoff_gap_max", (k <= TB_BACKOFF + 1), 1'b1);
            accept_req(16'h0100, 0);
        end
        give_status(2'd0, 2);
        stream(3, 16'h30, 1'b1, 1'b0);
        chk_stats(2, 1, 2);

        // 4: status timeout, then a stray status only accepted in the next WAIT
        send_meta(16'h0200);
        accept_req(16'h0200, 0);
        k = 0;
        while (sts_tready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'(TB_TIMEOUT));
        sts_tvalid = 1'b1;
        sts_tdata  = {2'd0, 62'h55};
        #1;
        chk("drop_sts_ready", sts_tready, 1'b0);
        stream(1, 16'h40, 1'b0, 1'b0);
        chk("idle_stray_sts_ready", sts_tready, 1'b0);
        chk_stats(2, 2, 2);
        send_meta(16'h0201);
        chk("req_stray_sts_ready", sts_tready, 1'b0);
        accept_req(16'h0201, 0);
        @(negedge clk);
        sts_tvalid = 1'b0;
        sts_tdata  = '0;
        stream(1, 16'h48, 1'b1, 1'b0);
        chk_stats(3, 2, 2);

        // 5: metadata backpressure and toggling data ready
        send_meta(16'h0300);
        accept_req(16'h0300, 10);
        give_status(2'd0, 0);
        stream(4, 16'h50, 1'b1, 1'b1);
        chk_stats(4, 2, 2);

        // 6: reset in the middle of SEND
        send_meta(16'h0abc);
        accept_req(16'h0abc, 0);
        give_status(2'd0, 0);
        s_data_valid = 1'b1;
        s_data_data  = beat_word(16'h60);
        s_data_last  = 1'b0;
        tx_tready    = 1'b0;
        #1;
        chk("t6_send_valid", tx_tvalid, 1'b1);
        aresetn      = 1'b0;
        s_meta_valid = 1'b1;
        s_meta_data  = 16'h0abd;
        tx_tready    = 1'b1;
        @(negedge clk);
        chk("t6_rst_tx_valid", tx_tvalid, 1'b0);
        chk("t6_rst_tx_data", tx_tdata, 512'h0);
        chk("t6_rst_tx_last", tx_tlast, 1'b0);
        chk("t6_rst_in_ready", s_data_ready, 1'b0);
        chk("t6_rst_meta_ready", s_meta_ready, 1'b0);
        chk("t6_rst_req_valid", meta_tvalid, 1'b0);
        chk("t6_rst_req_data", meta_tdata, 32'h0);
        chk("t6_rst_sts_ready", sts_tready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk_stats(0, 0, 0);
        aresetn      = 1'b1;
        s_meta_valid = 1'b0;
        s_data_valid = 1'b0;
        tx_tready    = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_idle_req_valid", meta_tvalid, 1'b0);
        send_meta(16'h0abd);
        accept_req(16'h0abd, 0);
        give_status(2'd0, 1);
        stream(1, 16'h70, 1'b1, 1'b0);
        chk_stats(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
